// File: rtl/wvb_pkg.sv
// Shared types and header layout for the waveform-buffer write controller.
// The header width follows from the LTC and address widths.
package wvb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WRITE,
    ST_HDR
  } wvb_state_t;

  localparam int HDR_TRUNC_POS = 0;
  localparam int HDR_CNST_POS  = 1;
  localparam int HDR_SRC_LSB   = 2;
  localparam int HDR_SRC_W     = 2;
  localparam int HDR_TAIL_W    = 4;

  function automatic int hdr_width(input int ltc_w, input int adr_w);
    return ltc_w + 2 * adr_w + HDR_TAIL_W;
  endfunction

  function automatic logic [HDR_TAIL_W-1:0] hdr_tail(
    input logic [HDR_SRC_W-1:0] src,
    input logic                 cnst,
    input logic                 trunc
  );
    return {src, cnst, trunc};
  endfunction

endpackage

// File: rtl/wvb_wr_ctrl_ext.sv
// Waveform RAM write controller: armed trigger, retrigger extension,
// length cap with truncation flag, auto re-arm and header strobe.
module wvb_wr_ctrl_ext
  import wvb_pkg::*;
#(
  parameter int P_ADR_WIDTH       = 12,
  parameter int P_LTC_WIDTH       = 48,
  parameter int P_PRE_CONF_WIDTH  = 5,
  parameter int P_POST_CONF_WIDTH = 8,
  parameter int P_LEN_WIDTH       = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [P_LTC_WIDTH-1:0]       ltc,
  input  logic                         arm,
  input  logic                         trig,
  input  logic [1:0]                   trig_src,
  input  logic                         overflow_in,
  input  logic [P_PRE_CONF_WIDTH-1:0]  pre_config,
  input  logic [P_POST_CONF_WIDTH-1:0] post_config,
  input  logic [P_LEN_WIDTH-1:0]       max_len_config,
  input  logic                         retrig_en,
  input  logic                         auto_rearm,
  input  logic                         cnst_run,
  input  logic [P_LEN_WIDTH-1:0]       cnst_config,
  output logic                         armed,
  output logic [P_ADR_WIDTH-1:0]       wvb_wr_addr,
  output logic                         wvb_wren,
  output logic                         eoe,
  output logic [hdr_width(P_LTC_WIDTH, P_ADR_WIDTH)-1:0] hdr_data,
  output logic                         hdr_wren,
  output logic                         overflow_out
);

  localparam int P_HDR_WIDTH = hdr_width(P_LTC_WIDTH, P_ADR_WIDTH);
  localparam int RW          = P_LEN_WIDTH + 1;

  wvb_state_t state, nxt;

  logic [P_ADR_WIDTH-1:0] wr_addr, start_q, stop_q;
  logic [RW-1:0]          remaining;
  logic [P_LEN_WIDTH-1:0] total, max_q;
  logic [P_LTC_WIDTH-1:0] ltc_q;
  logic [1:0]             src_q;
  logic                   cnst_q, trunc_q, retrig_q, ovf_q;

  logic [RW-1:0] len_pp, len_cn;
  logic          retrig, cap_hit, last, fin;

  assign len_pp = RW'(pre_config) + RW'(post_config) + RW'(1);
  assign len_cn = RW'(cnst_config) + RW'(1);

  // Cap beats retrigger; retrigger on the last write keeps the event open.
  assign retrig  = retrig_q && !cnst_q && trig;
  assign cap_hit = (max_q != '0) &&
                   (total + P_LEN_WIDTH'(1) == max_q);
  assign last    = (remaining == RW'(1)) && !retrig;
  assign fin     = cap_hit || last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (arm) nxt = ST_ARMED;
      ST_ARMED: if (trig && !overflow_in) nxt = ST_WRITE;
      ST_WRITE: if (fin) nxt = ST_HDR;
      ST_HDR:   nxt = auto_rearm ? ST_ARMED : ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      remaining <= '0;
      total     <= '0;
      max_q     <= '0;
      ltc_q     <= '0;
      src_q     <= '0;
      cnst_q    <= 1'b0;
      trunc_q   <= 1'b0;
      retrig_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state)
        ST_ARMED: begin
          if (trig && overflow_in) begin
            ovf_q <= 1'b1;
          end else if (trig) begin
            ltc_q     <= ltc;
            src_q     <= trig_src;
            start_q   <= wr_addr;
            cnst_q    <= cnst_run;
            retrig_q  <= retrig_en;
            max_q     <= max_len_config;
            remaining <= cnst_run ? len_cn : len_pp;
            total     <= '0;
          end
        end
        ST_WRITE: begin
          wr_addr   <= wr_addr + P_ADR_WIDTH'(1);
          total     <= total + P_LEN_WIDTH'(1);
          remaining <= retrig ? len_pp : remaining - RW'(1);
          if (fin) begin
            stop_q  <= wr_addr;
            trunc_q <= cap_hit;
          end
        end
        default: ;
      endcase
    end
  end

  assign armed        = (state == ST_ARMED);
  assign wvb_wren     = (state == ST_WRITE);
  assign eoe          = wvb_wren && fin;
  assign hdr_wren     = (state == ST_HDR);
  assign wvb_wr_addr  = wr_addr;
  assign overflow_out = ovf_q;
  assign hdr_data     = P_HDR_WIDTH'({ltc_q, start_q, stop_q,
                                      hdr_tail(src_q, cnst_q, trunc_q)});

endmodule

// File: tb/tb_wvb_wr_ctrl_ext.sv
// Bench for wvb_wr_ctrl_ext: directed scenarios plus random traffic,
// all checked against an event-level reference model.
module tb_wvb_wr_ctrl_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] ltc;
  logic        arm, trig;
  logic [1:0]  trig_src;
  logic        overflow_in;
  logic [4:0]  pre_config;
  logic [7:0]  post_config;
  logic [11:0] max_len_config;
  logic        retrig_en, auto_rearm, cnst_run;
  logic [11:0] cnst_config;
  logic        armed, wvb_wren, eoe, hdr_wren, overflow_out;
  logic [11:0] wvb_wr_addr;
  logic [75:0] hdr_data;

  always #5 clk = ~clk;

  wvb_wr_ctrl_ext dut (
    .clk(clk), .rst_n(rst_n), .ltc(ltc), .arm(arm), .trig(trig),
    .trig_src(trig_src), .overflow_in(overflow_in),
    .pre_config(pre_config), .post_config(post_config),
    .max_len_config(max_len_config), .retrig_en(retrig_en),
    .auto_rearm(auto_rearm), .cnst_run(cnst_run),
    .cnst_config(cnst_config), .armed(armed),
    .wvb_wr_addr(wvb_wr_addr), .wvb_wren(wvb_wren), .eoe(eoe),
    .hdr_data(hdr_data), .hdr_wren(hdr_wren),
    .overflow_out(overflow_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event model: an event ends at write index m_dl, or at the cap.
  int          m_mode, m_addr, m_n, m_dl, m_cap, m_start, m_stop;
  logic [47:0] m_ltc;
  logic [1:0]  m_src;
  bit          m_cf, m_tr, m_ren, m_ovf;

  logic [47:0] tick = 48'd0;
  localparam logic [47:0] LTC_BASE = 48'hA5C3_0000_0000;
  int          nwr;
  bit          hdr_seen;
  logic [75:0] last_hdr;

  function automatic void m_reset();
    m_mode = 0; m_addr = 0; m_n = 0; m_dl = 0; m_cap = 0;
    m_start = 0; m_stop = 0; m_ltc = '0; m_src = '0;
    m_cf = 0; m_tr = 0; m_ren = 0; m_ovf = 0;
  endfunction

  task automatic step();
    bit retr, capf, fin;
    logic [75:0] eh;
    ltc = LTC_BASE + tick;
    if (!rst_n) m_reset();
    #1;
    retr = (m_mode == 2) && m_ren && !m_cf && trig;
    capf = (m_mode == 2) && (m_cap != 0) && (m_n + 1 == m_cap);
    fin  = (m_mode == 2) && (capf || (m_n == m_dl && !retr));
    chk("armed", armed, m_mode == 1);
    chk("wren", wvb_wren, m_mode == 2);
    if (m_mode == 2) begin
      chk("addr", wvb_wr_addr, m_addr);
      nwr++;
    end
    chk("eoe", eoe, fin);
    chk("hdr_wren", hdr_wren, m_mode == 3);
    if (m_mode == 3) begin
      eh = {m_ltc, 12'(m_start), 12'(m_stop), m_src, m_cf, m_tr};
      chk("hdr_data", hdr_data, eh);
    end
    if (hdr_wren) begin
      last_hdr = hdr_data;
      hdr_seen = 1;
    end
    chk("ovf", overflow_out, m_ovf);
    if (!rst_n) begin
      chk("rst_addr", wvb_wr_addr, 0);
      chk("rst_hdr", hdr_data, 0);
    end
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      case (m_mode)
        0: if (arm) m_mode = 1;
        1: if (trig) begin
          if (overflow_in) m_ovf = 1;
          else begin
            m_ltc = ltc; m_src = trig_src; m_start = m_addr;
            m_cf = cnst_run; m_ren = retrig_en;
            m_cap = max_len_config; m_n = 0;
            m_dl = (cnst_run ? cnst_config + 1
                             : pre_config + post_config + 1) - 1;
            m_mode = 2;
          end
        end
        2: begin
          if (fin) begin
            m_stop = m_addr; m_tr = capf; m_mode = 3;
          end else if (retr) begin
            m_dl = m_n + pre_config + post_config + 1;
          end
          m_n++;
          m_addr = (m_addr + 1) % 4096;
        end
        default: m_mode = auto_rearm ? 1 : 0;
      endcase
    end
    @(negedge clk);
    tick++;
  endtask

  task automatic pulse_arm();
    arm = 1; step(); arm = 0;
  endtask

  task automatic pulse_trig();
    trig = 1; step(); trig = 0;
  endtask

  task automatic wait_hdr(int limit);
    for (int i = 0; i < limit && !hdr_seen; i++) step();
    chk("hdr_timeout", hdr_seen, 1);
  endtask

  task automatic start_ev();
    nwr = 0; hdr_seen = 0;
    pulse_trig();
  endtask

  logic [47:0] exp_ltc;

  initial begin
    m_reset();
    rst_n = 0; arm = 0; trig = 0; trig_src = 0; overflow_in = 0;
    pre_config = 3; post_config = 4; max_len_config = 0;
    retrig_en = 0; auto_rearm = 0; cnst_run = 0; cnst_config = 0;
    ltc = '0; nwr = 0; hdr_seen = 0; last_hdr = '0;
    @(negedge clk);
    step(); step();
    rst_n = 1;
    step();

    // basic 8-sample event
    trig_src = 2;
    pulse_arm();
    start_ev();
    wait_hdr(50);
    chk("basic_nwr", nwr, 8);
    chk("basic_start", last_hdr[27:16], 0);
    chk("basic_stop", last_hdr[15:4], 7);
    chk("basic_src", last_hdr[3:2], 2);
    chk("basic_trunc", last_hdr[0], 0);
    chk("basic_idle", armed, 0);

    // retrigger on the 6th write
    retrig_en = 1; trig_src = 1;
    pulse_arm();
    exp_ltc = LTC_BASE + tick;
    start_ev();
    repeat (5) step();
    trig = 1; step(); trig = 0;
    wait_hdr(50);
    chk("retrig_nwr", nwr, 14);
    chk("retrig_start", last_hdr[27:16], 8);
    chk("retrig_stop", last_hdr[15:4], 21);
    chk("retrig_ltc", last_hdr[75:28], exp_ltc);

    // same, capped at 10
    max_len_config = 10;
    pulse_arm();
    start_ev();
    repeat (5) step();
    trig = 1; step(); trig = 0;
    wait_hdr(50);
    chk("cap_nwr", nwr, 10);
    chk("cap_stop", last_hdr[15:4], 31);
    chk("cap_trunc", last_hdr[0], 1);
    max_len_config = 0; retrig_en = 0;

    // advance the write pointer to 4092
    cnst_run = 1; cnst_config = 12'd4059;
    pulse_arm();
    start_ev();
    wait_hdr(5000);
    chk("adv_stop", last_hdr[15:4], 4091);
    cnst_run = 0;

    // wrap with auto re-arm
    auto_rearm = 1;
    pulse_arm();
    start_ev();
    wait_hdr(50);
    chk("wrap_nwr", nwr, 8);
    chk("wrap_start", last_hdr[27:16], 4092);
    chk("wrap_stop", last_hdr[15:4], 3);
    chk("rearm", armed, 1);
    start_ev();
    wait_hdr(50);
    chk("rearm2_start", last_hdr[27:16], 4);
    chk("rearm2_stop", last_hdr[15:4], 11);

    // dropped trigger
    overflow_in = 1;
    pulse_trig();
    chk("ovf_out", overflow_out, 1);
    chk("ovf_armed", armed, 1);
    chk("ovf_nowren", wvb_wren, 0);
    overflow_in = 0;

    // constant length, retrigger ignored
    cnst_run = 1; cnst_config = 99; retrig_en = 1; auto_rearm = 0;
    start_ev();
    for (int i = 0; i < 200 && !hdr_seen; i++) begin
      trig = ($urandom % 3) == 0;
      step();
    end
    trig = 0;
    chk("cnst_done", hdr_seen, 1);
    chk("cnst_nwr", nwr, 100);
    chk("cnst_flag", last_hdr[1], 1);
    chk("cnst_stop", last_hdr[15:4], 111);
    cnst_run = 0; retrig_en = 0;

    // reset during the 4th write
    pulse_arm();
    start_ev();
    repeat (3) step();
    hdr_seen = 0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step(); step();
    chk("rst_nohdr", hdr_seen, 0);
    chk("rst_ovf", overflow_out, 0);
    pulse_arm();
    start_ev();
    wait_hdr(50);
    chk("rst_start", last_hdr[27:16], 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      arm            = ($urandom % 8) == 0;
      trig           = ($urandom % 5) == 0;
      overflow_in    = ($urandom % 12) == 0;
      trig_src       = 2'($urandom);
      pre_config     = 5'($urandom % 8);
      post_config    = 8'($urandom % 12);
      max_len_config = (($urandom % 3) == 0) ? 12'($urandom % 20) : 12'd0;
      retrig_en      = 1'($urandom);
      auto_rearm     = 1'($urandom);
      cnst_run       = ($urandom % 6) == 0;
      cnst_config    = 12'($urandom % 16);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wvb_wr_ctrl_ext.md
Name: wvb_wr_ctrl_ext

Overview:
Next-generation waveform-buffer write controller. It drives the circular waveform RAM write address and enable from an armed trigger. It adds retrigger extension, a configurable maximum-length cap with truncation flag, auto re-arm, and a parametrised header. It sits between the pretrigger buffer / trigger logic and the waveform+header storage, and replaces the single-shot write controller.

Parameters:
P_ADR_WIDTH, 12, waveform RAM address width; addresses wrap modulo 2^P_ADR_WIDTH
P_LTC_WIDTH, 48, local time counter width
P_PRE_CONF_WIDTH, 5, pretrigger sample count config width
P_POST_CONF_WIDTH, 8, posttrigger sample count config width
P_LEN_WIDTH, 12, length counter / max_len_config width
P_HDR_WIDTH, P_LTC_WIDTH+2*P_ADR_WIDTH+4 (76), header width; derived, must not be overridden

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ltc  in  P_LTC_WIDTH  local time counter
arm  in  1  arm request pulse
trig  in  1  trigger (already qualified by pretrigger-ready)
trig_src  in  2  trigger source code
overflow_in  in  1  storage cannot accept another maximum-length waveform
pre_config  in  P_PRE_CONF_WIDTH  pretrigger samples
post_config  in  P_POST_CONF_WIDTH  posttrigger samples
max_len_config  in  P_LEN_WIDTH  length cap; 0 = no cap
retrig_en  in  1  enable retrigger extension
auto_rearm  in  1  return to ARMED after header write
cnst_run  in  1  constant-length mode
cnst_config  in  P_LEN_WIDTH  constant length minus 1
armed  out  1  high in ARMED
wvb_wr_addr  out  P_ADR_WIDTH  write address
wvb_wren  out  1  write enable
eoe  out  1  end-of-event, high with the final write
hdr_data  out  P_HDR_WIDTH  {ltc[47:0], start_addr, stop_addr, trig_src, cnst_flag, truncated}
hdr_wren  out  1  header write strobe
overflow_out  out  1  sticky dropped-trigger flag

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, wr_addr=0, counters 0. An in-flight waveform is abandoned; no header is written.
- States: IDLE, ARMED, WRITE, HDR.
- IDLE: arm=1 -> ARMED next cycle. trig in IDLE is ignored, including when it coincides with arm.
- ARMED: armed=1.
  - trig && overflow_in: trigger dropped, overflow_out set, stay ARMED. overflow_out clears only on reset.
  - trig && !overflow_in: accept trigger. Latch ltc, trig_src, start_addr=wr_addr and cnst_flag=cnst_run.
  - Load remaining = cnst_run ? cnst_config+1 : pre_config+post_config+1, zero-extended to P_LEN_WIDTH+1. Clear total count. Go to WRITE. No write occurs in the accept cycle.
- WRITE: wvb_wren=1 every cycle, using the current wr_addr. wr_addr increments after each write and wraps 2^P_ADR_WIDTH-1 -> 0. total increments and remaining decrements per write.
- Retrigger: retrig_en && !cnst_flag && trig in a WRITE cycle.
  - The current write counts.
  - remaining reloads to pre_config+post_config+1 further writes.
  - ltc, start_addr and trig_src are not updated.
  - This applies on the would-be final cycle too; in that case eoe is suppressed.
- Cap: if max_len_config!=0 and total+1==max_len_config on a write, that write is final and truncated=1. The cap takes precedence over a retrigger in the same cycle.
- Final write (remaining==1 or cap): eoe=1 with that write, stop_addr=that address -> HDR.
- HDR: hdr_wren=1 for exactly one cycle with the packed header. Next state is ARMED if auto_rearm, else IDLE. trig during HDR is ignored.
- Config inputs are sampled only at trigger acceptance (and at retrigger for pre/post); mid-write changes are ignored.
- overflow_in is ignored in WRITE/HDR: the overflow controller guarantees space for max length.

Decomposition:
- Package wvb_pkg: state encoding, header field offsets/widths, header-pack function, derived P_HDR_WIDTH rule.
- No sub-module; the length counter and FSM are a single process.

Test Plan:
- Basic: pre=3, post=4, arm, trig at wr_addr=0 -> wren 8 cycles at addr 0..7, eoe at addr 7, hdr_wren next cycle with start=0, stop=7, truncated=0, then IDLE/armed=0.
- Retrigger: same config, retrig_en=1, trig on 6th write (addr 5) -> writes continue to addr 13, single header start=0, stop=13, ltc from first trigger.
- Cap: retrigger case with max_len_config=10 -> last write addr 9 with eoe, header stop=9, truncated=1.
- Wrap/auto re-arm: start wr_addr=4092, L=8, auto_rearm=1 -> addrs 4092..4095, 0..3, stop=3; armed=1 the cycle after hdr_wren; second trig is accepted.
- Overflow/constant: overflow_in=1 at trig -> no wren, overflow_out=1, still armed. Then overflow_in=0, cnst_run=1, cnst_config=99 -> 100 writes, cnst_flag=1, retrigger ignored.
- Reset mid-write: rst_n low at 4th write -> all outputs 0 asynchronously, no hdr_wren; after release, arm+trig -> write starts at addr 0.
